// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// serial line levels.
package uart_pkg;

    // 3-bit state encoding for the transmit FSM
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP_2 = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP1  = ST_STOP1,
        STOP_2 = ST_STOP_2
    } tx_state_e;

    // Serial line levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// The register shifts right so the payload leaves LSB first; the counter
// tracks which payload bit is on the line and saturates at the last bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  clear,
    input  logic                  shift,
    output logic                  bit_lsb,
    output logic                  bit_next,
    output logic                  done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;

    // Load a new payload, or shift out one bit per DATA cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= '0;
        end else begin
            if (shift) begin
                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
            if (clear) begin
                cnt <= '0;
            end else if (shift && !done) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // bit_next is the bit that becomes the LSB after the next shift
    always_comb begin
        bit_lsb  = shreg[0];
        bit_next = shreg[1];
        done     = (cnt == LAST_IDX);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, parity latch and registered line
// outputs. One CLK cycle is one bit time.
// Optional feature macro: UART_TX_BACK2BACK_EN -- when defined, a request
// during the final stop bit starts the next frame with no idle cycle.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (line low)
// DATA   | payload bits, LSB first
// PARITY | latched parity bit
// STOP1  | first stop bit (final one unless two stop bits latched)
// STOP_2 | second stop bit, always final
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Frame_Done
);

    tx_state_e state;
    tx_state_e state_nxt;

    logic par_en_q;
    logic par_bit_q;
    logic stop2_q;

    logic final_stop;
    logic can_accept;
    logic accept;
    logic ser_clear;
    logic ser_shift;
    logic ser_lsb;
    logic ser_next;
    logic ser_done;

    logic tx_nxt;
    logic busy_nxt;
    logic done_nxt;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .load_data(P_DATA),
        .clear    (ser_clear),
        .shift    (ser_shift),
        .bit_lsb  (ser_lsb),
        .bit_next (ser_next),
        .done     (ser_done)
    );

    // Decide where a new request may be taken
    always_comb begin
        final_stop = ((state == STOP1) && !stop2_q) || (state == STOP_2);
`ifdef UART_TX_BACK2BACK_EN
        can_accept = (state == IDLE) || final_stop;
`else
        can_accept = (state == IDLE);
`endif
        accept = Data_Valid && can_accept;
    end

    // Next-state logic and next-cycle line/status values
    always_comb begin
        state_nxt = state;
        ser_clear = 1'b0;
        ser_shift = 1'b0;
        tx_nxt    = IDLE_LINE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                state_nxt = DATA;
                ser_clear = 1'b1;
            end
            DATA: begin
                ser_shift = 1'b1;
                if (ser_done) state_nxt = par_en_q ? PARITY : STOP1;
            end
            PARITY: begin
                state_nxt = STOP1;
            end
            STOP1: begin
                if (stop2_q)     state_nxt = STOP_2;
                else if (accept) state_nxt = START;
                else             state_nxt = IDLE;
            end
            STOP_2: begin
                state_nxt = accept ? START : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are derived from the state being entered so that they
        // can be registered together with it. Entering DATA from START
        // presents the freshly loaded LSB; staying in DATA presents the
        // bit that the concurrent shift moves into the LSB.
        case (state_nxt)
            IDLE:    tx_nxt = IDLE_LINE;
            START:   tx_nxt = START_BIT;
            DATA:    tx_nxt = (state == DATA) ? ser_next : ser_lsb;
            PARITY:  tx_nxt = par_bit_q;
            STOP1:   tx_nxt = STOP_BIT;
            STOP_2:  tx_nxt = STOP_BIT;
            default: tx_nxt = IDLE_LINE;
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == STOP_2) || ((state_nxt == STOP1) && !stop2_q);
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            TX_OUT     <= IDLE_LINE;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            state      <= state_nxt;
            TX_OUT     <= tx_nxt;
            Busy       <= busy_nxt;
            Frame_Done <= done_nxt;
        end
    end

    // Per-frame configuration and parity, captured at acceptance
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (accept) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            stop2_q   <= STOP2;
        end
    end

endmodule
